// File: rtl/debug_pkg.sv
// Shared definitions for the debug display path: display modes and the
// constant helpers that size channel, page and prescaler indices.
package debug_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE      = 2'd0,
        MODE_HOLD      = 2'd1,
        MODE_SCAN      = 2'd2,
        MODE_SCAN_HOLD = 2'd3
    } mode_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int digit_bits(input int digits);
        return 4 * digits;
    endfunction

    function automatic int page_count(input int w, input int digits);
        return (w + digit_bits(digits) - 1) / digit_bits(digits);
    endfunction

endpackage

// File: rtl/debug_monitor_if.sv
// Probe/display bundle between the CPU debug outputs and the monitor.
// master: drives probes, select, page, mode, capture; slave: drives display.
interface debug_monitor_if
    import debug_pkg::*;
#(
    parameter int NCH    = 8,
    parameter int W      = 64,
    parameter int DIGITS = 8
);
    localparam int CW = idx_w(NCH);
    localparam int PW = idx_w(page_count(W, DIGITS));

    logic [NCH*W-1:0]    iProbes;
    logic [CW-1:0]       iSel;
    logic [PW-1:0]       iPage;
    logic [1:0]          iMode;
    logic                iCapture;

    logic [4*DIGITS-1:0] oNibbles;
    logic [7*DIGITS-1:0] oHex;
    logic [CW-1:0]       oChannel;
    logic                oValid;
    logic                oFrozen;
    logic                oDiff;
    logic [7:0]          oCapCount;

    modport master (
        output iProbes, iSel, iPage, iMode, iCapture,
        input  oNibbles, oHex, oChannel, oValid, oFrozen, oDiff, oCapCount
    );

    modport slave (
        input  iProbes, iSel, iPage, iMode, iCapture,
        output oNibbles, oHex, oChannel, oValid, oFrozen, oDiff, oCapCount
    );

endinterface

// File: rtl/debug_scan_timer.sv
// Auto-scan timer: prescaler plus wrapping channel counter, loaded on scan entry.
// Ports: clk, rst (async high), scan_en (scan mode active), sel (entry channel), chan.
module debug_scan_timer
    import debug_pkg::*;
#(
    parameter int NCH      = 8,
    parameter int SCAN_DIV = 50000000,
    parameter int CW       = idx_w(NCH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scan_en,
    input  logic [CW-1:0] sel,
    output logic [CW-1:0] chan
);

    localparam int PRE_W = idx_w(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [CW-1:0]    CH_LAST  = CW'(NCH - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CW-1:0]    chan_q, chan_d;
    logic             prev_scan_q;
    logic             entry;

    // Only a transition from a non-scan mode restarts the scan; moving
    // between the two scan modes keeps phase and channel.
    assign entry = scan_en & ~prev_scan_q;

    always_comb begin
        pre_d  = pre_q;
        chan_d = chan_q;
        if (entry) begin
            pre_d  = '0;
            chan_d = (int'(sel) < NCH) ? sel : '0;
        end else if (scan_en) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                chan_d = (chan_q == CH_LAST) ? '0 : chan_q + CW'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q       <= '0;
            chan_q      <= '0;
            prev_scan_q <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            chan_q      <= chan_d;
            prev_scan_q <= scan_en;
        end
    end

    assign chan = chan_q;

endmodule

// File: rtl/decoder7.sv
// Hex nibble to seven-segment pattern, active-high, bit order gfedcba.
// Ports: nibble (4-bit value in), seg (7-bit segment pattern out).
module decoder7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        unique case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
    end

endmodule

// File: rtl/debug_monitor.sv
// Debug display path: selects a probe channel (live or snapshot), pages it
// onto DIGITS hex digits and drives the seven-segment patterns.
// Ports: iClock, iReset (async high), bus (slave side of debug_monitor_if).
module debug_monitor
    import debug_pkg::*;
#(
    parameter int NCH      = 8,
    parameter int W        = 64,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000000
) (
    input  logic            iClock,
    input  logic            iReset,
    debug_monitor_if.slave  bus
);

    localparam int CW    = idx_w(NCH);
    localparam int PAGES = page_count(W, DIGITS);
    localparam int DW    = digit_bits(DIGITS);
    localparam int XW    = PAGES * DW;

    logic             cap_q;
    logic             cap_edge;
    logic [NCH*W-1:0] snap_q;
    logic [7:0]       cap_cnt_q;
    logic [DW-1:0]    nib_q, nib_d;
    logic             diff_q, diff_d;

    logic             scan_en;
    logic             hold_src;
    logic [CW-1:0]    scan_ch;
    logic [CW-1:0]    ch;
    logic             valid;

    logic [W-1:0]     live_w;
    logic [W-1:0]     snap_w;
    logic [W-1:0]     sel_w;
    logic [XW-1:0]    ext;
    logic [DW-1:0]    page_v;
    logic             page_ok;
    logic [7*DIGITS-1:0] hex;

    assign scan_en  = (bus.iMode == MODE_SCAN) || (bus.iMode == MODE_SCAN_HOLD);
    assign hold_src = (bus.iMode == MODE_HOLD) || (bus.iMode == MODE_SCAN_HOLD);
    assign cap_edge = bus.iCapture & ~cap_q;

    debug_scan_timer #(
        .NCH      (NCH),
        .SCAN_DIV (SCAN_DIV),
        .CW       (CW)
    ) u_scan (
        .clk     (iClock),
        .rst     (iReset),
        .scan_en (scan_en),
        .sel     (bus.iSel),
        .chan    (scan_ch)
    );

    assign ch    = scan_en ? scan_ch : bus.iSel;
    assign valid = int'(ch) < NCH;

    // Live and snapshot words of the displayed channel; zero when out of range.
    always_comb begin
        live_w = '0;
        snap_w = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(ch) == k) begin
                live_w = bus.iProbes[k*W +: W];
                snap_w = snap_q[k*W +: W];
            end
        end
    end

    assign sel_w = hold_src ? snap_w : live_w;

    // Zero-extend to a whole number of pages so the last page pads with 0.
    assign ext = XW'(sel_w);

    always_comb begin
        page_v  = '0;
        page_ok = 1'b0;
        for (int p = 0; p < PAGES; p++) begin
            if (int'(bus.iPage) == p) begin
                page_v  = ext[p*DW +: DW];
                page_ok = 1'b1;
            end
        end
    end

    assign nib_d  = (valid && page_ok) ? page_v : '0;
    assign diff_d = valid && (live_w != snap_w);

    // The display register samples pre-edge snapshot contents, so a capture
    // at edge t shows in HOLD only after edge t+1.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            cap_q     <= 1'b0;
            snap_q    <= '0;
            cap_cnt_q <= '0;
            nib_q     <= '0;
            diff_q    <= 1'b0;
        end else begin
            cap_q  <= bus.iCapture;
            nib_q  <= nib_d;
            diff_q <= diff_d;
            if (cap_edge) begin
                snap_q <= bus.iProbes;
                if (cap_cnt_q != 8'hFF) begin
                    cap_cnt_q <= cap_cnt_q + 8'd1;
                end
            end
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        decoder7 u_dec (
            .nibble (nib_q[4*i +: 4]),
            .seg    (hex[7*i +: 7])
        );
    end

    assign bus.oNibbles  = nib_q;
    assign bus.oHex      = hex;
    assign bus.oChannel  = ch;
    assign bus.oValid    = valid;
    assign bus.oFrozen   = bus.iMode[0];
    assign bus.oDiff     = diff_q;
    assign bus.oCapCount = cap_cnt_q;

endmodule
